gomoku_board_engine: RTL and testbench

//  Parametrised NxN gomoku rules engine: holds board state, accepts moves over a valid/ready handshake,

---
 rtl/gomoku_pkg.sv | 52 +++++
 rtl/gomoku_dir_step.sv | 47 ++++
 rtl/gomoku_board_engine.sv | 201 ++++++++++++++++++++
 tb/tb_gomoku_board_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gomoku_pkg.sv
// gomoku_pkg: shared types for the gomoku rules engine.
//   cell_e   : 2-bit board cell code (EMPTY/BLACK/WHITE)
//   result_e : game result code (RES_NONE/RES_BLACK/RES_WHITE/RES_DRAW)
//   state_e  : engine FSM state
//   dir_e    : line-scan direction, with dir_vec() giving its (dx,dy) step
package gomoku_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BLACK = 2'd1,
      WHITE = 2'd2
   } cell_e;

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_BLACK = 2'd1,
      RES_WHITE = 2'd2,
      RES_DRAW  = 2'd3
   } result_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_RESOLVE,
      ST_OVER
   } state_e;

   // dx steps the row (x), dy steps the column (y)
   typedef enum logic [1:0] {
      DIR_H = 2'd0,   // (0, 1)
      DIR_V = 2'd1,   // (1, 0)
      DIR_D = 2'd2,   // (1, 1)
      DIR_A = 2'd3    // (1,-1)
   } dir_e;

   typedef struct packed {
      logic signed [1:0] dx;
      logic signed [1:0] dy;
   } step_t;

   function automatic step_t dir_vec(input dir_e d);
      step_t v;
      unique case (d)
         DIR_H:   v = '{dx: 2'sd0, dy: 2'sd1};
         DIR_V:   v = '{dx: 2'sd1, dy: 2'sd0};
         DIR_D:   v = '{dx: 2'sd1, dy: 2'sd1};
         default: v = '{dx: 2'sd1, dy: -2'sd1};
      endcase
      return v;
   endfunction

endpackage

// File: rtl/gomoku_dir_step.sv
// gomoku_dir_step: combinational target-cell generator for the line scanner.
//   base_x_i/base_y_i : coordinate of the stone being evaluated
//   dir_i             : scan direction
//   side_i            : 0 = positive side (+k), 1 = negative side (-k)
//   k_i               : distance from the base stone
//   tgt_x_o/tgt_y_o   : target coordinate (meaningful only when in_bounds_o)
//   in_bounds_o       : target lies on the board
module gomoku_dir_step
   import gomoku_pkg::*;
#(
   parameter int N  = 7,
   parameter int CW = $clog2(N)
) (
   input  logic [CW-1:0] base_x_i,
   input  logic [CW-1:0] base_y_i,
   input  dir_e          dir_i,
   input  logic          side_i,
   input  logic [CW-1:0] k_i,
   output logic [CW-1:0] tgt_x_o,
   output logic [CW-1:0] tgt_y_o,
   output logic          in_bounds_o
);

   localparam logic [CW:0] NB = (CW+1)'(N);

   step_t              vec;
   logic signed [CW:0] delta;
   logic signed [CW:0] bx, by, tx, ty;

   // Signed CW+1 arithmetic: a step off either edge goes negative or reaches
   // N, so it is caught here instead of wrapping into the next row.
   always_comb begin
      vec   = dir_vec(dir_i);
      delta = side_i ? -$signed({1'b0, k_i}) : $signed({1'b0, k_i});
      bx    = $signed({1'b0, base_x_i});
      by    = $signed({1'b0, base_y_i});
      tx    = bx;
      ty    = by;
      if (vec.dx != 2'sd0) tx = vec.dx[1] ? bx - delta : bx + delta;
      if (vec.dy != 2'sd0) ty = vec.dy[1] ? by - delta : by + delta;
      in_bounds_o = !tx[CW] && !ty[CW] &&
                    ({1'b0, tx[CW-1:0]} < NB) && ({1'b0, ty[CW-1:0]} < NB);
      tgt_x_o = tx[CW-1:0];
      tgt_y_o = ty[CW-1:0];
   end

endmodule

// File: rtl/gomoku_board_engine.sv
// gomoku_board_engine: NxN gomoku rules engine.
//   CLOCK_50, resetn (sync, active-low), new_game (sync soft clear)
//   move_valid/move_ready, move_x/move_y : move request handshake
//   move_done   : pulse, legal move placed and resolved with no game end
//   move_reject : pulse, move out of range or onto an occupied cell
//   turn, game_over, result, stone_count : game status
//   rd_x/rd_y -> rd_cell : combinational board read port for display
// Win detection walks outward from the last stone, one cell per cycle, over
// the four line directions.
module gomoku_board_engine
   import gomoku_pkg::*;
#(
   parameter  int N       = 7,
   parameter  int WIN_LEN = 5,
   localparam int CW      = $clog2(N)
) (
   input  logic          CLOCK_50,
   input  logic          resetn,
   input  logic          new_game,
   input  logic          move_valid,
   output logic          move_ready,
   input  logic [CW-1:0] move_x,
   input  logic [CW-1:0] move_y,
   output logic          move_done,
   output logic          move_reject,
   output logic          turn,
   output logic          game_over,
   output logic [1:0]    result,
   output logic [7:0]    stone_count,
   input  logic [CW-1:0] rd_x,
   input  logic [CW-1:0] rd_y,
   output logic [1:0]    rd_cell
);

   localparam int unsigned CELLS_U = N * N;
   localparam int          IW      = $clog2(N * N);
   localparam int          CNT_W   = $clog2(WIN_LEN + 1);
   localparam logic [7:0]  CELLS   = 8'(N * N);
   localparam logic [CW:0] NB      = (CW+1)'(N);

   cell_e            board_q [CELLS_U];
   state_e           state_q;
   logic             turn_q;
   result_e          result_q;
   logic             game_over_q;
   logic [7:0]       stone_count_q;
   logic             move_done_q;
   logic             move_reject_q;
   logic [CW-1:0]    bx_q, by_q, k_q;
   cell_e            colour_q;
   logic [CNT_W-1:0] cnt_q;
   dir_e             dir_q;
   logic             side_q;
   logic             win_q;

   // Move acceptance decode
   logic          acc_in_range;
   logic [IW-1:0] acc_idx;
   cell_e         acc_cell_d;

   always_comb begin
      acc_in_range = ({1'b0, move_x} < NB) && ({1'b0, move_y} < NB);
      acc_idx      = IW'(N * move_x + move_y);
      acc_cell_d   = EMPTY;
      if (acc_in_range) acc_cell_d = board_q[acc_idx];
   end

   // Scan target
   logic [CW-1:0] tgt_x, tgt_y;
   logic          tgt_in;
   logic [IW-1:0] tgt_idx;
   cell_e         tgt_cell_d;
   logic          match_d;

   gomoku_dir_step #(
      .N  (N),
      .CW (CW)
   ) u_step (
      .base_x_i    (bx_q),
      .base_y_i    (by_q),
      .dir_i       (dir_q),
      .side_i      (side_q),
      .k_i         (k_q),
      .tgt_x_o     (tgt_x),
      .tgt_y_o     (tgt_y),
      .in_bounds_o (tgt_in)
   );

   always_comb begin
      tgt_idx    = IW'(N * tgt_x + tgt_y);
      tgt_cell_d = EMPTY;
      if (tgt_in) tgt_cell_d = board_q[tgt_idx];
      match_d = tgt_in && (tgt_cell_d == colour_q);
   end

   // Display read port
   logic          rd_in_range;
   logic [IW-1:0] rd_idx;

   always_comb begin
      rd_in_range = ({1'b0, rd_x} < NB) && ({1'b0, rd_y} < NB);
      rd_idx      = IW'(N * rd_x + rd_y);
      rd_cell     = EMPTY;
      if (rd_in_range) rd_cell = board_q[rd_idx];
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn || new_game) begin
         state_q       <= ST_IDLE;
         turn_q        <= 1'b0;
         result_q      <= RES_NONE;
         game_over_q   <= 1'b0;
         stone_count_q <= '0;
         move_done_q   <= 1'b0;
         move_reject_q <= 1'b0;
         bx_q          <= '0;
         by_q          <= '0;
         k_q           <= '0;
         colour_q      <= EMPTY;
         cnt_q         <= '0;
         dir_q         <= DIR_H;
         side_q        <= 1'b0;
         win_q         <= 1'b0;
         for (int unsigned i = 0; i < CELLS_U; i++) board_q[i] <= EMPTY;
      end else begin
         move_done_q   <= 1'b0;
         move_reject_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (move_valid) begin
                  if (!acc_in_range || acc_cell_d != EMPTY) begin
                     move_reject_q <= 1'b1;
                  end else begin
                     board_q[acc_idx] <= turn_q ? WHITE : BLACK;
                     colour_q         <= turn_q ? WHITE : BLACK;
                     stone_count_q    <= stone_count_q + 8'd1;
                     bx_q             <= move_x;
                     by_q             <= move_y;
                     cnt_q            <= CNT_W'(1);
                     dir_q            <= DIR_H;
                     side_q           <= 1'b0;
                     k_q              <= CW'(1);
                     win_q            <= 1'b0;
                     state_q          <= ST_SCAN;
                  end
               end
            end
            ST_SCAN: begin
               if (match_d) begin
                  // count is about to reach WIN_LEN: stop scanning at once
                  if (cnt_q == CNT_W'(WIN_LEN - 1)) begin
                     win_q   <= 1'b1;
                     state_q <= ST_RESOLVE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                     k_q   <= k_q + 1'b1;
                  end
               end else if (!side_q) begin
                  // positive side ended; the run so far carries to the other side
                  side_q <= 1'b1;
                  k_q    <= CW'(1);
               end else if (dir_q == DIR_A) begin
                  state_q <= ST_RESOLVE;
               end else begin
                  dir_q  <= dir_e'(dir_q + 2'd1);
                  side_q <= 1'b0;
                  k_q    <= CW'(1);
                  cnt_q  <= CNT_W'(1);
               end
            end
            ST_RESOLVE: begin
               if (win_q) begin
                  result_q    <= (colour_q == WHITE) ? RES_WHITE : RES_BLACK;
                  game_over_q <= 1'b1;
                  state_q     <= ST_OVER;
               end else if (stone_count_q == CELLS) begin
                  result_q    <= RES_DRAW;
                  game_over_q <= 1'b1;
                  state_q     <= ST_OVER;
               end else begin
                  turn_q      <= ~turn_q;
                  move_done_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            ST_OVER: begin
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign move_ready  = (state_q == ST_IDLE);
   assign move_done   = move_done_q;
   assign move_reject = move_reject_q;
   assign turn        = turn_q;
   assign game_over   = game_over_q;
   assign result      = result_q;
   assign stone_count = stone_count_q;

endmodule

// File: tb/tb_gomoku_board_engine.sv
// Scoreboard bench: stimulus pushes the expected event (done/reject/over+result)
// for each move; per-instance monitors pop and compare when the DUT signals one.
module tb_gomoku_board_engine;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic resetn;

   // Instance A: N=7, WIN_LEN=5
   logic       a_new, a_valid, a_ready, a_done, a_rej, a_turn, a_over;
   logic [2:0] a_x, a_y, a_rx, a_ry;
   logic [1:0] a_res, a_cell;
   logic [7:0] a_cnt;

   // Instance B: N=3, WIN_LEN=3
   logic       b_new, b_valid, b_ready, b_done, b_rej, b_turn, b_over;
   logic [1:0] b_x, b_y, b_rx, b_ry;
   logic [1:0] b_res, b_cell;
   logic [7:0] b_cnt;

   gomoku_board_engine #(.N(7), .WIN_LEN(5)) dut_a (
      .CLOCK_50(clk), .resetn(resetn), .new_game(a_new),
      .move_valid(a_valid), .move_ready(a_ready), .move_x(a_x), .move_y(a_y),
      .move_done(a_done), .move_reject(a_rej), .turn(a_turn), .game_over(a_over),
      .result(a_res), .stone_count(a_cnt), .rd_x(a_rx), .rd_y(a_ry), .rd_cell(a_cell)
   );

   gomoku_board_engine #(.N(3), .WIN_LEN(3)) dut_b (
      .CLOCK_50(clk), .resetn(resetn), .new_game(b_new),
      .move_valid(b_valid), .move_ready(b_ready), .move_x(b_x), .move_y(b_y),
      .move_done(b_done), .move_reject(b_rej), .turn(b_turn), .game_over(b_over),
      .result(b_res), .stone_count(b_cnt), .rd_x(b_rx), .rd_y(b_ry), .rd_cell(b_cell)
   );

   int checks   = 0;
   int failures = 0;

   // kind: 0 = move_done, 1 = move_reject, 2 = game_over rise (with result)
   typedef struct {
      int kind;
      int res;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pop_cmp(input bit b, input int kind, input int res);
      exp_t  e;
      string nm;
      int    sz;
      nm = b ? "evB" : "evA";
      sz = b ? qb.size() : qa.size();
      if (sz == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_unexpected: got event kind %0d expected none", nm, kind);
         return;
      end
      if (b) e = qb.pop_front();
      else   e = qa.pop_front();
      check({nm, "_kind"}, kind, e.kind);
      if (kind == 2) check({nm, "_result"}, res, e.res);
   endtask

   // Monitors
   logic a_over_p = 1'b0;
   logic b_over_p = 1'b0;

   always @(negedge clk) begin
      if (a_done) pop_cmp(1'b0, 0, 0);
      if (a_rej)  pop_cmp(1'b0, 1, 0);
      if (a_over && !a_over_p) pop_cmp(1'b0, 2, int'(a_res));
      a_over_p <= a_over;
   end

   always @(negedge clk) begin
      if (b_done) pop_cmp(1'b1, 0, 0);
      if (b_rej)  pop_cmp(1'b1, 1, 0);
      if (b_over && !b_over_p) pop_cmp(1'b1, 2, int'(b_res));
      b_over_p <= b_over;
   end

   function automatic bit rdy(input bit b);
      return b ? b_ready : a_ready;
   endfunction

   function automatic bit ovr(input bit b);
      return b ? b_over : a_over;
   endfunction

   // Issue one move, expecting event 'kind'; lat = cycles from accept edge to
   // the DUT being back in IDLE or game over.
   task automatic move(input bit b, input int x, input int y,
                       input int kind, input int res, output int lat);
      exp_t e;
      int   n;
      lat    = 0;
      e.kind = kind;
      e.res  = res;
      if (b) qb.push_back(e);
      else   qa.push_back(e);
      n = 0;
      @(negedge clk);
      while (!rdy(b) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         check("ready_wait_timeout", 0, 1);
         return;
      end
      if (b) begin b_x = 2'(x); b_y = 2'(y); b_valid = 1'b1; end
      else   begin a_x = 3'(x); a_y = 3'(y); a_valid = 1'b1; end
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rdy(b) && !ovr(b) && lat < 200);
      if (lat >= 200) check("resolve_timeout", 0, 1);
   endtask

   task automatic rd_a(input string name, input int x, input int y, input int exp);
      a_rx = 3'(x);
      a_ry = 3'(y);
      #1;
      check(name, int'(a_cell), exp);
   endtask

   task automatic soft_clear_a();
      @(negedge clk);
      a_new = 1'b1;
      @(negedge clk);
      a_new = 1'b0;
   endtask

   // Move lists: {x, y}
   int t2[9][2]  = '{'{3,0},'{0,0},'{3,1},'{0,1},'{3,2},'{0,2},'{3,3},'{0,3},'{3,4}};
   int t4[10][2] = '{'{0,0},'{1,5},'{0,1},'{2,4},'{0,2},'{4,2},'{6,6},'{5,1},'{6,5},'{3,3}};
   int t5[9][2]  = '{'{0,0},'{0,1},'{0,2},'{1,1},'{1,0},'{2,0},'{1,2},'{2,2},'{2,1}};
   int t6[9][2]  = '{'{0,4},'{6,0},'{0,5},'{6,1},'{0,6},'{6,3},'{1,0},'{5,5},'{1,1}};

   initial begin
      int lat;
      resetn  = 1'b0;
      a_new   = 1'b0; a_valid = 1'b0; a_x = '0; a_y = '0; a_rx = '0; a_ry = '0;
      b_new   = 1'b0; b_valid = 1'b0; b_x = '0; b_y = '0; b_rx = '0; b_ry = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // 1: reset state
      check("rst_turn",   int'(a_turn),  0);
      check("rst_result", int'(a_res),   0);
      check("rst_ready",  int'(a_ready), 1);
      check("rst_count",  int'(a_cnt),   0);
      check("rst_over",   int'(a_over),  0);
      check("rstB_ready", int'(b_ready), 1);
      check("rstB_count", int'(b_cnt),   0);
      for (int x = 0; x < 7; x++)
         for (int y = 0; y < 7; y++)
            rd_a("rst_cell", x, y, 0);

      // 2: horizontal black win, then moves ignored
      for (int i = 0; i < 9; i++)
         move(1'b0, t2[i][0], t2[i][1], (i == 8) ? 2 : 0, 1, lat);
      check("t2_result", int'(a_res),   1);
      check("t2_over",   int'(a_over),  1);
      check("t2_ready",  int'(a_ready), 0);
      check("t2_count",  int'(a_cnt),   9);
      rd_a("t2_cell_b",   3, 0, 1);
      rd_a("t2_cell_w",   0, 3, 2);
      rd_a("t2_cell_oor", 7, 0, 0);
      @(negedge clk);
      a_x = 3'd5; a_y = 3'd5; a_valid = 1'b1;
      repeat (4) @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      check("t2_ign_count",  int'(a_cnt), 9);
      check("t2_ign_result", int'(a_res), 1);
      rd_a("t2_ign_cell", 5, 5, 0);

      // 3: occupied rejection
      soft_clear_a();
      check("t3_clr_result", int'(a_res),   0);
      check("t3_clr_over",   int'(a_over),  0);
      check("t3_clr_ready",  int'(a_ready), 1);
      rd_a("t3_clr_cell", 3, 0, 0);
      move(1'b0, 2, 2, 0, 0, lat);
      move(1'b0, 2, 2, 1, 0, lat);
      check("t3_turn",  int'(a_turn), 1);
      check("t3_count", int'(a_cnt),  1);
      rd_a("t3_cell", 2, 2, 1);

      // 4: anti-diagonal white win, last stone mid-run
      soft_clear_a();
      for (int i = 0; i < 10; i++)
         move(1'b0, t4[i][0], t4[i][1], (i == 9) ? 2 : 0, 2, lat);
      check("t4_result", int'(a_res),  2);
      check("t4_count",  int'(a_cnt),  10);
      check("t4_latency_ok", int'(lat <= 8 * (5 - 1) + 2), 1);

      // 5: draw on 3x3
      for (int i = 0; i < 9; i++)
         move(1'b1, t5[i][0], t5[i][1], (i == 8) ? 2 : 0, 3, lat);
      check("t5_result", int'(b_res),  3);
      check("t5_over",   int'(b_over), 1);
      check("t5_count",  int'(b_cnt),  9);
      b_rx = 2'd2; b_ry = 2'd2; #1;
      check("t5_cell", int'(b_cell), 2);

      // 6: out of range, corners, row-wrap, new_game mid-scan
      soft_clear_a();
      move(1'b0, 7, 0, 1, 0, lat);
      check("t6_oor_turn",  int'(a_turn), 0);
      check("t6_oor_count", int'(a_cnt),  0);
      move(1'b0, 6, 6, 0, 0, lat);
      move(1'b0, 0, 0, 0, 0, lat);
      check("t6_corner_over",  int'(a_over), 0);
      check("t6_corner_count", int'(a_cnt),  2);
      soft_clear_a();
      for (int i = 0; i < 9; i++)
         move(1'b0, t6[i][0], t6[i][1], 0, 0, lat);
      check("t6_wrap_over",  int'(a_over), 0);
      check("t6_wrap_count", int'(a_cnt),  9);
      check("t6_wrap_turn",  int'(a_turn), 1);
      @(negedge clk);
      a_x = 3'd3; a_y = 3'd3; a_valid = 1'b1;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      @(negedge clk);
      check("t6_in_scan", int'(a_ready), 0);
      a_new = 1'b1;
      @(posedge clk);
      #1;
      a_new = 1'b0;
      @(negedge clk);
      check("t6_ng_ready",  int'(a_ready), 1);
      check("t6_ng_count",  int'(a_cnt),   0);
      check("t6_ng_result", int'(a_res),   0);
      check("t6_ng_turn",   int'(a_turn),  0);
      rd_a("t6_ng_cell", 3, 3, 0);
      repeat (40) @(negedge clk);

      check("qa_drained", qa.size(), 0);
      check("qb_drained", qb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
